// File: rtl/egm_pkg.sv
// egm_pkg: shared FSM state type, timing constants and a saturating-add helper
// used by egm_multi_channel and egm_channel.
package egm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        DONE
    } egm_state_e;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_PERIOD  = 4;
    localparam int SAT_W       = 64;

    // Adds a and b, clamping the result to the largest w-bit value (w <= SAT_W).
    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input int unsigned      w);
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
        return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/egm_channel.sv
// egm_channel: one response channel -- synchroniser, edge detector, latency
// counter and statistics. Max-latency register exists only with EGM_MAX_LAT_EN.
module egm_channel
    import egm_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic             clkin_50,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             run_active,
    input  logic             pulse_start,
    input  logic             period_end,
    input  logic             response,
    output logic [SUM_W-1:0] lat_sum,
    output logic [15:0]      miss_cnt
`ifdef EGM_MAX_LAT_EN
    ,
    output logic [CNT_W-1:0] lat_max
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       lat_q, lat_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [15:0]            miss_q, miss_d;
    logic [CNT_W-1:0]       hit_lat;
    logic                   rise;
`ifdef EGM_MAX_LAT_EN
    logic [CNT_W-1:0]       max_q, max_d;
`endif

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    // lat_q lags the stimulus by the arming cycle; the synchroniser delay is
    // folded in so the reported latency is true delay + SYNC_STAGES.
    assign hit_lat = CNT_W'(sat_add(SAT_W'(lat_q), SAT_W'(SYNC_STAGES), CNT_W));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], response};
        prev_d  = sync_q[SYNC_STAGES-1];
        armed_d = armed_q;
        lat_d   = lat_q;
        sum_d   = sum_q;
        miss_d  = miss_q;
`ifdef EGM_MAX_LAT_EN
        max_d   = max_q;
`endif
        if (clear) begin
            armed_d = 1'b0;
            lat_d   = '0;
            sum_d   = '0;
            miss_d  = '0;
`ifdef EGM_MAX_LAT_EN
            max_d   = '0;
`endif
        end else if (!en || !run_active) begin
            armed_d = 1'b0;
        end else if (pulse_start) begin
            armed_d = 1'b1;
            lat_d   = '0;
        end else if (armed_q) begin
            lat_d = (lat_q == '1) ? lat_q : lat_q + CNT_W'(1);
            // A hit wins over period_end when both land in the same cycle.
            if (rise) begin
                armed_d = 1'b0;
                sum_d   = SUM_W'(sat_add(SAT_W'(sum_q), SAT_W'(hit_lat), SUM_W));
`ifdef EGM_MAX_LAT_EN
                if (hit_lat > max_q) max_d = hit_lat;
`endif
            end else if (period_end) begin
                armed_d = 1'b0;
                miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed in always_comb.
    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            lat_q   <= '0;
            sum_q   <= '0;
            miss_q  <= '0;
`ifdef EGM_MAX_LAT_EN
            max_q   <= '0;
`endif
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            lat_q   <= lat_d;
            sum_q   <= sum_d;
            miss_q  <= miss_d;
`ifdef EGM_MAX_LAT_EN
            max_q   <= max_d;
`endif
        end
    end

    assign lat_sum  = sum_q;
    assign miss_cnt = miss_q;
`ifdef EGM_MAX_LAT_EN
    assign lat_max  = max_q;
`endif

endmodule

// File: rtl/egm_multi_channel.sv
// egm_multi_channel: pulse-train FSM broadcasting one stimulus to NUM_CH
// response channels. Define EGM_MAX_LAT_EN to add the per-channel lat_max port.
module egm_multi_channel
    import egm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int SUM_W  = 32
) (
    input  logic                    clkin_50,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [CNT_W-1:0]        period,
    input  logic [CNT_W-1:0]        width,
    input  logic [15:0]             pulses,
    output logic [NUM_CH-1:0]       stimulus,
    input  logic [NUM_CH-1:0]       response,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pulses_sent,
    output logic [NUM_CH*SUM_W-1:0] lat_sum,
    output logic [NUM_CH*16-1:0]    miss_cnt
`ifdef EGM_MAX_LAT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] lat_max
`endif
);

    egm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  width_q, width_d;
    logic [15:0]       pulses_q, pulses_d;
    logic [15:0]       sent_q, sent_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] stim_q, stim_d;
    logic [CNT_W-1:0]  period_c, width_c;
    logic              clear, pulse_start, period_end, run_active;

    assign run_active  = (state_q == HIGH) || (state_q == LOW);
    assign pulse_start = (state_q == HIGH) && (phase_q == '0);
    // An abort suppresses the period_end strobe so no miss is booked for it.
    assign period_end  = (state_q == LOW) && (phase_q == period_q - CNT_W'(1)) && !abort;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        period_d = period_q;
        width_d  = width_q;
        pulses_d = pulses_q;
        sent_d   = sent_q;
        en_d     = en_q;
        clear    = 1'b0;

        period_c = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
        if (width == '0)            width_c = CNT_W'(1);
        else if (width >= period_c) width_c = period_c - CNT_W'(1);
        else                        width_c = width;

        case (state_q)
            IDLE: if (start) begin
                clear    = 1'b1;
                period_d = period_c;
                width_d  = width_c;
                pulses_d = pulses;
                en_d     = ch_en;
                sent_d   = '0;
                phase_d  = '0;
                state_d  = (pulses == '0) ? DONE : HIGH;
            end
            HIGH: begin
                if (phase_q == '0) sent_d = sent_q + 16'd1;
                phase_d = phase_q + CNT_W'(1);
                if (phase_q == width_q - CNT_W'(1)) state_d = LOW;
            end
            LOW: begin
                phase_d = phase_q + CNT_W'(1);
                if (phase_q == period_q - CNT_W'(1)) begin
                    phase_d = '0;
                    state_d = (sent_q == pulses_q) ? DONE : HIGH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && run_active) state_d = DONE;

        stim_d = (state_d == HIGH) ? en_d : '0;
    end

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            period_q <= '0;
            width_q  <= '0;
            pulses_q <= '0;
            sent_q   <= '0;
            en_q     <= '0;
            stim_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            width_q  <= width_d;
            pulses_q <= pulses_d;
            sent_q   <= sent_d;
            en_q     <= en_d;
            stim_q   <= stim_d;
        end
    end

    assign stimulus    = stim_q;
    assign busy        = run_active;
    assign done        = (state_q == DONE);
    assign pulses_sent = sent_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        egm_channel #(
            .CNT_W(CNT_W),
            .SUM_W(SUM_W)
        ) u_ch (
            .clkin_50   (clkin_50),
            .rst        (rst),
            .en         (en_q[i]),
            .clear      (clear),
            .run_active (run_active),
            .pulse_start(pulse_start),
            .period_end (period_end),
            .response   (response[i]),
            .lat_sum    (lat_sum[i*SUM_W +: SUM_W]),
            .miss_cnt   (miss_cnt[i*16 +: 16])
`ifdef EGM_MAX_LAT_EN
            ,
            .lat_max    (lat_max[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_egm_multi_channel.sv
// Directed self-checking bench for egm_multi_channel; responses are delayed
// copies of the stimulus with per-channel delays in cycles (0 = never responds).
module tb_egm_multi_channel;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int SUM_W  = 32;

    logic                    clkin_50 = 1'b0;
    logic                    rst      = 1'b1;
    logic                    start    = 1'b0;
    logic                    abort    = 1'b0;
    logic [NUM_CH-1:0]       ch_en    = '0;
    logic [CNT_W-1:0]        period   = '0;
    logic [CNT_W-1:0]        width    = '0;
    logic [15:0]             pulses   = '0;
    logic [NUM_CH-1:0]       response = '0;
    logic [NUM_CH-1:0]       stimulus;
    logic                    busy;
    logic                    done;
    logic [15:0]             pulses_sent;
    logic [NUM_CH*SUM_W-1:0] lat_sum;
    logic [NUM_CH*16-1:0]    miss_cnt;
`ifdef EGM_MAX_LAT_EN
    logic [NUM_CH*CNT_W-1:0] lat_max;
`endif

    int                total = 0;
    int                bad   = 0;
    int                dly[NUM_CH];
    logic [63:0]       hist;
    logic              prev_any;
    int                sched[3];
    int                sched_idx;
    bit                sched_on;
    logic [NUM_CH-1:0] stim_or;
    int                stim0_hi;

    always #5 clkin_50 = ~clkin_50;

    egm_multi_channel #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .SUM_W (SUM_W)
    ) dut (
        .clkin_50   (clkin_50),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .ch_en      (ch_en),
        .period     (period),
        .width      (width),
        .pulses     (pulses),
        .stimulus   (stimulus),
        .response   (response),
        .busy       (busy),
        .done       (done),
        .pulses_sent(pulses_sent),
        .lat_sum    (lat_sum),
        .miss_cnt   (miss_cnt)
`ifdef EGM_MAX_LAT_EN
        ,
        .lat_max    (lat_max)
`endif
    );

    function automatic logic [SUM_W-1:0] sum_of(input int i);
        return lat_sum[i*SUM_W +: SUM_W];
    endfunction

    function automatic logic [15:0] miss_of(input int i);
        return miss_cnt[i*16 +: 16];
    endfunction

`ifdef EGM_MAX_LAT_EN
    function automatic logic [CNT_W-1:0] max_of(input int i);
        return lat_max[i*CNT_W +: CNT_W];
    endfunction
`endif

    // Advance to the next falling edge and update the response model there.
    task automatic step();
        @(negedge clkin_50);
        if (sched_on && (|stimulus) && !prev_any && sched_idx < 3) begin
            dly[0] = sched[sched_idx];
            sched_idx++;
        end
        prev_any = |stimulus;
        hist     = {hist[62:0], |stimulus};
        for (int i = 0; i < NUM_CH; i++)
            response[i] = (dly[i] > 0) ? hist[dly[i]-1] : 1'b0;
        stim_or  = stim_or | stimulus;
        stim0_hi = stim0_hi + int'(stimulus[0]);
    endtask

    // Returns at the falling edge of the first stimulus cycle (start + 1).
    task automatic start_run(input logic [NUM_CH-1:0] en, input int per, input int wid,
                             input int np, input bit use_sched);
        step();
        hist      = '0;
        prev_any  = 1'b0;
        stim_or   = '0;
        stim0_hi  = 0;
        sched_on  = use_sched;
        sched_idx = 0;
        ch_en     = en;
        period    = CNT_W'(per);
        width     = CNT_W'(wid);
        pulses    = 16'(np);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int n, output bit ok);
        n = 0;
        while (!done && n < max_cycles) begin
            step();
            n++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if (stimulus !== 4'h0) begin bad++; $display("FAIL reset_stim: got %h want 0", stimulus); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
        total++; if (pulses_sent !== 16'd0) begin bad++; $display("FAIL reset_sent: got %0d want 0", pulses_sent); end
        total++; if (lat_sum !== '0 || miss_cnt !== '0) begin bad++; $display("FAIL reset_stats: sum=%h miss=%h want 0", lat_sum, miss_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n; bit ok;
        dly = '{4, 4, 4, 4};
        start_run(4'hF, 10, 3, 5, 1'b0);
        total++; if (stimulus !== 4'hF || busy !== 1'b1) begin bad++; $display("FAIL basic_rise: stim=%h busy=%b want f 1", stimulus, busy); end
        wait_done(200, n, ok);
        total++; if (!ok || n != 50) begin bad++; $display("FAIL basic_done_time: got %0d cycles (done=%b) want 50", n, ok); end
        total++; if (pulses_sent !== 16'd5 || busy !== 1'b0) begin bad++; $display("FAIL basic_sent: sent=%0d busy=%b want 5 0", pulses_sent, busy); end
        for (int i = 0; i < NUM_CH; i++) begin
            total++; if (sum_of(i) !== 32'd30 || miss_of(i) !== 16'd0) begin bad++; $display("FAIL basic_stats ch%0d: sum=%0d miss=%0d want 30 0", i, sum_of(i), miss_of(i)); end
        end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_mask();
        int n; bit ok;
        dly = '{4, 4, 0, 4};
        start_run(4'b0101, 8, 2, 4, 1'b0);
        wait_done(100, n, ok);
        total++; if (!ok || n != 32) begin bad++; $display("FAIL mask_done_time: got %0d want 32", n); end
        total++; if ((stim_or & 4'b1010) !== 4'b0000 || stim_or !== 4'b0101) begin bad++; $display("FAIL mask_stim: seen=%b want 0101", stim_or); end
        total++; if (sum_of(0) !== 32'd24 || miss_of(0) !== 16'd0) begin bad++; $display("FAIL mask_ch0: sum=%0d miss=%0d want 24 0", sum_of(0), miss_of(0)); end
        total++; if (miss_of(2) !== 16'd4 || sum_of(2) !== 32'd0) begin bad++; $display("FAIL mask_ch2: miss=%0d sum=%0d want 4 0", miss_of(2), sum_of(2)); end
        total++; if (sum_of(1) !== 32'd0 || sum_of(3) !== 32'd0 || miss_of(1) !== 16'd0 || miss_of(3) !== 16'd0) begin bad++; $display("FAIL mask_disabled: sums=%0d,%0d miss=%0d,%0d want 0", sum_of(1), sum_of(3), miss_of(1), miss_of(3)); end
    endtask

    task automatic test_clamp();
        int n; bit ok;
        dly = '{1, 0, 0, 0};
        start_run(4'b0001, 2, 0, 3, 1'b0);
        step();
        total++; if (stimulus[0] !== 1'b0) begin bad++; $display("FAIL clamp_width: stim0=%b want 0 on second cycle", stimulus[0]); end
        wait_done(100, n, ok);
        total++; if (!ok || n != 11) begin bad++; $display("FAIL clamp_period: done after %0d more cycles want 11", n); end
        total++; if (stim0_hi != 3) begin bad++; $display("FAIL clamp_high_cycles: got %0d want 3", stim0_hi); end
        total++; if (sum_of(0) !== 32'd9 || miss_of(0) !== 16'd0) begin bad++; $display("FAIL clamp_stats: sum=%0d miss=%0d want 9 0", sum_of(0), miss_of(0)); end
    endtask

    task automatic test_edge_at_period_end();
        int n; bit ok;
        dly = '{4, 5, 0, 0};
        start_run(4'b0011, 6, 2, 3, 1'b0);
        wait_done(100, n, ok);
        total++; if (!ok || n != 18) begin bad++; $display("FAIL edge_done_time: got %0d want 18", n); end
        total++; if (sum_of(0) !== 32'd18 || miss_of(0) !== 16'd0) begin bad++; $display("FAIL edge_last_cycle_hit: sum=%0d miss=%0d want 18 0", sum_of(0), miss_of(0)); end
        total++; if (miss_of(1) !== 16'd3 || sum_of(1) !== 32'd0) begin bad++; $display("FAIL edge_too_late: miss=%0d sum=%0d want 3 0", miss_of(1), sum_of(1)); end
    endtask

    task automatic test_zero_pulses();
        dly = '{0, 0, 0, 0};
        start_run(4'hF, 10, 3, 0, 1'b0);
        total++; if (done !== 1'b1 || busy !== 1'b0 || stimulus !== 4'h0) begin bad++; $display("FAIL zero_done: done=%b busy=%b stim=%h want 1 0 0", done, busy, stimulus); end
        total++; if (pulses_sent !== 16'd0 || sum_of(0) !== 32'd0) begin bad++; $display("FAIL zero_clear: sent=%0d sum0=%0d want 0 0", pulses_sent, sum_of(0)); end
    endtask

    task automatic test_abort();
        dly = '{3, 0, 0, 0};
        start_run(4'hF, 8, 4, 8, 1'b0);
        repeat (17) step();
        total++; if (stimulus !== 4'hF || pulses_sent !== 16'd3) begin bad++; $display("FAIL abort_pre: stim=%h sent=%0d want f 3", stimulus, pulses_sent); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (stimulus !== 4'h0 || done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_stop: stim=%h done=%b busy=%b want 0 1 0", stimulus, done, busy); end
        total++; if (pulses_sent !== 16'd3) begin bad++; $display("FAIL abort_sent: got %0d want 3", pulses_sent); end
        total++; if (sum_of(0) !== 32'd10 || miss_of(1) !== 16'd2 || miss_of(0) !== 16'd0) begin bad++; $display("FAIL abort_stats: sum0=%0d miss1=%0d miss0=%0d want 10 2 0", sum_of(0), miss_of(1), miss_of(0)); end
        repeat (5) step();
        total++; if (sum_of(0) !== 32'd10 || miss_of(1) !== 16'd2 || done !== 1'b0) begin bad++; $display("FAIL abort_hold: sum0=%0d miss1=%0d done=%b want 10 2 0", sum_of(0), miss_of(1), done); end
    endtask

    task automatic test_reset_mid_run();
        int n; bit ok;
        dly = '{3, 3, 3, 3};
        start_run(4'hF, 6, 2, 10, 1'b0);
        repeat (14) step();
        total++; if (sum_of(1) === 32'd0 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre: sum1=%0d busy=%b want nonzero 1", sum_of(1), busy); end
        #1 rst = 1'b1;
        #1;
        total++; if (stimulus !== 4'h0 || busy !== 1'b0 || pulses_sent !== 16'd0) begin bad++; $display("FAIL rst_async: stim=%h busy=%b sent=%0d want 0 0 0", stimulus, busy, pulses_sent); end
        total++; if (lat_sum !== '0 || miss_cnt !== '0) begin bad++; $display("FAIL rst_async_stats: sum=%h miss=%h want 0", lat_sum, miss_cnt); end
        step();
        step();
        rst = 1'b0;
        dly   = '{3, 4, 4, 4};
        sched = '{3, 7, 5};
        start_run(4'hF, 12, 3, 3, 1'b1);
        wait_done(100, n, ok);
        total++; if (!ok || n != 36) begin bad++; $display("FAIL rst_rerun_time: got %0d want 36", n); end
        total++; if (sum_of(0) !== 32'd21 || sum_of(1) !== 32'd18) begin bad++; $display("FAIL rst_rerun_sum: sum0=%0d sum1=%0d want 21 18", sum_of(0), sum_of(1)); end
        total++; if (miss_cnt !== '0 || pulses_sent !== 16'd3) begin bad++; $display("FAIL rst_rerun_miss: miss=%h sent=%0d want 0 3", miss_cnt, pulses_sent); end
`ifdef EGM_MAX_LAT_EN
        total++; if (max_of(0) !== 16'd9 || max_of(1) !== 16'd6) begin bad++; $display("FAIL rst_rerun_max: max0=%0d max1=%0d want 9 6", max_of(0), max_of(1)); end
`endif
    endtask

    initial begin
        dly       = '{0, 0, 0, 0};
        sched     = '{0, 0, 0};
        hist      = '0;
        prev_any  = 1'b0;
        sched_on  = 1'b0;
        sched_idx = 0;
        stim_or   = '0;
        stim0_hi  = 0;
        test_reset();
        test_basic();
        test_mask();
        test_clamp();
        test_edge_at_period_end();
        test_zero_pulses();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/egm_multi_channel.md
# egm_multi_channel

Parametrised multi-channel stimulus/response tester. Generalises the single-channel EGM stimulus/response pair to NUM_CH channels. All enabled channels receive one common pulse train. Each channel measures the latency of its own response, accumulates the total, and counts missed responses. It sits beside the Qsys system, driven by PIO-style control/status wires from the Nios side.

## Interface
Parameters:
- NUM_CH, 4, number of stimulus/response channels
- CNT_W, 16, width of period/width/latency counters
- SUM_W, 32, width of per-channel latency accumulators

Ports:
- clkin_50  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  1-cycle request to begin a run; ignored while busy
- abort  in  1  ends the run at the next cycle; goes to DONE
- ch_en  in  NUM_CH  channel enable mask, latched at start
- period  in  CNT_W  cycles per pulse period, latched at start
- width  in  CNT_W  stimulus high cycles, latched at start
- pulses  in  16  number of pulses in the run, latched at start
- stimulus  out  NUM_CH  registered stimulus outputs
- response  in  NUM_CH  asynchronous DUT responses
- busy  out  1  high from the cycle after start until DONE
- done  out  1  1-cycle pulse at end of run
- pulses_sent  out  16  pulses issued in the current or last run
- lat_sum  out  NUM_CH*SUM_W  per-channel latency sum; channel i is in bits [i*SUM_W +: SUM_W]
- miss_cnt  out  NUM_CH*16  per-channel missed-response count
- lat_max  out  NUM_CH*CNT_W  per-channel maximum latency (only with EGM_MAX_LAT_EN)

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE + start:
  - latch the parameters;
  - clamp period below 4 to 4;
  - clamp width to the range 1..period-1;
  - clear all statistics;
  - if pulses==0, go to DONE; otherwise go to HIGH.
- HIGH:
  - stimulus = ch_en for width cycles, then go to LOW.
  - pulses_sent increments on the first HIGH cycle.
- LOW:
  - stimulus = 0 for period-width cycles.
  - At period end: if pulses_sent==pulses, go to DONE; otherwise go to HIGH.
- DONE: done=1 for one cycle, then IDLE.
- abort in HIGH or LOW: go to DONE next cycle; stimulus drops to 0 on that same cycle.
- Per channel (enabled channels only):
  - response passes through a 2-FF synchroniser, then a rising-edge detector.
  - On the first HIGH cycle, set armed=1 and lat=0.
  - While armed, lat increments each cycle and saturates at all-ones.
  - A rising edge while armed: clear armed, add lat to lat_sum (saturating), update lat_max.
  - Period end while still armed: clear armed and increment miss_cnt (saturating at 16'hFFFF).
  - An edge on the same cycle as period end counts as a hit, not a miss.
  - A response that is already high at the stimulus rise gives no edge. It is a miss unless it falls and rises again within the period.
  - Edges while not armed are ignored; at most one hit per pulse.
  - abort while armed: no miss is counted for that pulse.
- Disabled channels: stimulus held 0, statistics held at 0.
- Statistics hold their values in IDLE until the next accepted start.

## Timing
- Reset: state=IDLE; stimulus=0; busy=0; done=0; all counters, sums and maxima 0; synchronisers 0.
- start sampled in cycle T: stimulus rises at T+1; busy rises at T+1.
- Measured latency = true response delay + 2 synchroniser cycles, deterministic. Example: response rising before the clock edge k cycles after stimulus rises gives lat = k+2.
- One pulse occupies exactly period cycles: width cycles HIGH plus period-width cycles LOW.
- done pulses one cycle after the final LOW cycle; busy falls in that same cycle.
- Statistics are final in the cycle done=1.

## Configuration
- EGM_MAX_LAT_EN defined:
  - lat_max port and per-channel max registers exist;
  - lat_max updates on each hit if lat exceeds the stored value.
- EGM_MAX_LAT_EN undefined: the lat_max port and its logic are absent; everything else is unchanged.

## Structure
- Package egm_pkg holds:
  - FSM state enum (IDLE, HIGH, LOW, DONE);
  - SYNC_STAGES=2;
  - MIN_PERIOD=4;
  - a saturating-add function.
- Sub-module egm_channel, generated NUM_CH times, contains:
  - the synchroniser;
  - the edge detector;
  - armed flag and latency counter;
  - accumulator, miss counter and max register.
- The top level holds the FSM, phase counter and pulse counter. It broadcasts pulse_start and period_end strobes to every channel.

## Test plan
- period=10, width=3, pulses=5, ch_en=4'b1111, each response rises 4 cycles after stimulus rises -> per channel lat_sum=30, miss_cnt=0; pulses_sent=5; done exactly 50 cycles after stimulus first rises.
- ch_en=4'b0101, channel 2 response never rises -> stimulus[1] and stimulus[3] stay 0; channel 0 miss_cnt=0; channel 2 miss_cnt=pulses.
- period=2, width=0 -> clamped to period=4, width=1; stimulus high 1 of every 4 cycles.
- Response edge exactly on the last cycle of a period -> counted as a hit, miss_cnt unchanged.
- abort mid-HIGH on pulse 3 of 8 -> stimulus=0 on the next cycle; done pulses; pulses_sent=3; no miss counted for pulse 3.
- rst asserted mid-run, then a new start -> all outputs 0 immediately; the next run's statistics are correct. With EGM_MAX_LAT_EN and latencies 3, 7, 5 -> lat_max=9 (7+2 sync).
